// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures high time and period of an asynchronous PWM input in clk_in cycles, flags a stuck input.
module pwm_duty_decoder #(
  parameter int COUNTER_WIDTH = 8,
  parameter int MAX_COUNT = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     pwm_in,
  output logic [COUNTER_WIDTH-1:0] high_count_out,
  output logic [COUNTER_WIDTH-1:0] period_count_out,
  output logic                     valid_out,
  output logic                     timeout_out,
  output logic                     level_out
);
  localparam logic [COUNTER_WIDTH-1:0] MAX = COUNTER_WIDTH'(MAX_COUNT);
  localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);
  typedef enum logic [1:0] {WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic s, s_d, rise, fall;
  logic [COUNTER_WIDTH-1:0] per_cnt, hi_cnt, per_nx, hi_nx, high_nx, period_nx;
  logic valid_nx, timeout_nx, level_nx;
  assign s = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      sync <= '0;
      s_d <= 1'b0;
      state <= WAIT_RISE;
      per_cnt <= '0;
      hi_cnt <= '0;
      high_count_out <= '0;
      period_count_out <= '0;
      valid_out <= 1'b0;
      timeout_out <= 1'b0;
      level_out <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      s_d <= s;
      state <= state_nx;
      per_cnt <= per_nx;
      hi_cnt <= hi_nx;
      high_count_out <= high_nx;
      period_count_out <= period_nx;
      valid_out <= valid_nx;
      timeout_out <= timeout_nx;
      level_out <= level_nx;
    end
  // A rise always wins over a simultaneous timeout; timeout latches once until the next rise.
  always_comb begin
    state_nx = state;
    per_nx = per_cnt + COUNTER_WIDTH'(per_cnt != MAX);
    hi_nx = hi_cnt;
    high_nx = high_count_out;
    period_nx = period_count_out;
    valid_nx = 1'b0;
    timeout_nx = timeout_out;
    level_nx = level_out;
    if (rise) begin
      state_nx = MEAS_HIGH;
      per_nx = ONE;
      hi_nx = ONE;
      timeout_nx = 1'b0;
      high_nx = state == MEAS_LOW ? hi_cnt : high_count_out;
      period_nx = state == MEAS_LOW ? per_cnt : period_count_out;
      valid_nx = state == MEAS_LOW;
    end else if (per_cnt == MAX && !timeout_out) begin
      state_nx = WAIT_RISE;
      timeout_nx = 1'b1;
      level_nx = s;
    end else if (state == MEAS_HIGH) begin
      hi_nx = fall ? hi_cnt : hi_cnt + ONE;
      state_nx = fall ? MEAS_LOW : MEAS_HIGH;
    end
  end
endmodule
